// File: rtl/ones_comp_seq_muldiv.sv
// Iterative one's-complement multiply/divide unit, one shift-add or restoring-subtract step per cycle.
// Build with OCMD_DIV_EN defined for the divider datapath; otherwise divides report overflow.
module ones_comp_seq_muldiv #(
  parameter int unsigned WIDTH = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               op,
  input  logic [2*WIDTH-1:0] opa,
  input  logic [WIDTH-1:0]   opb,
  output logic [WIDTH-1:0]   result_hi,
  output logic [WIDTH-1:0]   result_lo,
  output logic               busy,
  output logic               done,
  output logic               div_zero,
  output logic               overflow
);

  localparam int unsigned MW = WIDTH - 1;
  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LastStep = CW'(MW - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      step_q, step_d;
  logic               sign_q, sign_d;
  logic [MW-1:0]      low_q, low_d;
  logic [2*MW-1:0]    mcand_q, mcand_d;
  logic [2*MW-1:0]    prod_q, prod_d;
  logic [WIDTH-1:0]   res_hi_q, res_hi_d;
  logic [WIDTH-1:0]   res_lo_q, res_lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;

  logic               a_sign, b_sign;
  logic [MW-1:0]      a_mag, b_mag;
  logic [2*MW-1:0]    mul_prod;
  logic [2*WIDTH-1:0] prod_word;

  // A -0 operand collapses to magnitude 0 here.
  assign a_sign   = opa[WIDTH-1];
  assign b_sign   = opb[WIDTH-1];
  assign a_mag    = a_sign ? ~opa[MW-1:0] : opa[MW-1:0];
  assign b_mag    = b_sign ? ~opb[MW-1:0] : opb[MW-1:0];
  assign mul_prod = low_q[0] ? (prod_q + mcand_q) : prod_q;

`ifdef OCMD_DIV_EN
  logic               op_q, op_d;
  logic               nsign_q, nsign_d;
  logic [MW-1:0]      dmag_q, dmag_d;
  logic [MW-1:0]      rem_q, rem_d;
  logic               dz_q, dz_d;
  logic               n_sign;
  logic [2*WIDTH-2:0] n_mag;
  logic [WIDTH-1:0]   n_top;
  logic               div_err;
  logic [MW+1:0]      trial;
  logic               unused_trial_bit;

  assign n_sign  = opa[2*WIDTH-1];
  assign n_mag   = n_sign ? ~opa[2*WIDTH-2:0] : opa[2*WIDTH-2:0];
  assign n_top   = n_mag[2*WIDTH-2:WIDTH-1];
  // Upper numerator half >= denominator means the quotient needs more than MW bits.
  assign div_err = (b_mag == '0) || (n_top >= {1'b0, b_mag});
  assign trial   = {1'b0, rem_q, low_q[MW-1]} - {2'b00, dmag_q};
  assign unused_trial_bit = trial[MW];
  assign div_zero = dz_q;

  function automatic logic [WIDTH-1:0] oc_word(input logic neg, input logic [MW-1:0] mag);
    return (neg && (|mag)) ? ~{1'b0, mag} : {1'b0, mag};
  endfunction
`else
  logic unused_opa_hi;
  assign unused_opa_hi = ^opa[2*WIDTH-1:WIDTH];
  assign div_zero      = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    sign_d    = sign_q;
    low_d     = low_q;
    mcand_d   = mcand_q;
    prod_d    = prod_q;
    res_hi_d  = res_hi_q;
    res_lo_d  = res_lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ovf_d     = ovf_q;
    prod_word = '0;
`ifdef OCMD_DIV_EN
    op_d    = op_q;
    nsign_d = nsign_q;
    dmag_d  = dmag_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
`endif

    case (state_q)
      StIdle: begin
        if (start) begin
          step_d = '0;
          ovf_d  = 1'b0;
`ifdef OCMD_DIV_EN
          op_d = op;
          dz_d = 1'b0;
`endif
          if (!op) begin
            sign_d  = a_sign ^ b_sign;
            mcand_d = {{MW{1'b0}}, a_mag};
            prod_d  = '0;
            low_d   = b_mag;
            state_d = StCalc;
            busy_d  = 1'b1;
          end else begin
`ifdef OCMD_DIV_EN
            sign_d  = n_sign ^ b_sign;
            nsign_d = n_sign;
            dmag_d  = b_mag;
            rem_d   = n_mag[2*WIDTH-3:WIDTH-1];
            low_d   = n_mag[WIDTH-2:0];
            if (div_err) begin
              dz_d     = (b_mag == '0);
              ovf_d    = (b_mag != '0);
              res_hi_d = '0;
              res_lo_d = '0;
              state_d  = StDone;
              done_d   = 1'b1;
            end else begin
              state_d = StCalc;
              busy_d  = 1'b1;
            end
`else
            ovf_d    = 1'b1;
            res_hi_d = '0;
            res_lo_d = '0;
            state_d  = StDone;
            done_d   = 1'b1;
`endif
          end
        end
      end

      StCalc: begin
        step_d  = step_q + CW'(1);
        prod_d  = mul_prod;
        mcand_d = mcand_q << 1;
        low_d   = low_q >> 1;
`ifdef OCMD_DIV_EN
        // Quotient bits shift into low as the numerator bits shift out.
        if (op_q) begin
          if (!trial[MW+1]) begin
            rem_d = trial[MW-1:0];
            low_d = {low_q[MW-2:0], 1'b1};
          end else begin
            rem_d = {rem_q[MW-2:0], low_q[MW-1]};
            low_d = {low_q[MW-2:0], 1'b0};
          end
        end
`endif
        if (step_q == LastStep) begin
          state_d   = StDone;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          prod_word = {2'b00, prod_d};
          if (sign_q && (|prod_d)) prod_word = ~prod_word;
          res_hi_d  = prod_word[2*WIDTH-1:WIDTH];
          res_lo_d  = prod_word[WIDTH-1:0];
`ifdef OCMD_DIV_EN
          if (op_q) begin
            res_hi_d = oc_word(sign_q, low_d);
            res_lo_d = oc_word(nsign_q, rem_d);
          end
`endif
        end
      end

      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      step_q   <= '0;
      sign_q   <= 1'b0;
      low_q    <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef OCMD_DIV_EN
      op_q     <= 1'b0;
      nsign_q  <= 1'b0;
      dmag_q   <= '0;
      rem_q    <= '0;
      dz_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      sign_q   <= sign_d;
      low_q    <= low_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
`ifdef OCMD_DIV_EN
      op_q     <= op_d;
      nsign_q  <= nsign_d;
      dmag_q   <= dmag_d;
      rem_q    <= rem_d;
      dz_q     <= dz_d;
`endif
    end
  end

  assign result_hi = res_hi_q;
  assign result_lo = res_lo_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_ones_comp_seq_muldiv.sv
// Directed bench for ones_comp_seq_muldiv at WIDTH=15; expectations follow OCMD_DIV_EN.
module tb_ones_comp_seq_muldiv;

  localparam int W = 15;

  logic           clk;
  logic           rst;
  logic           start;
  logic           op;
  logic [2*W-1:0] opa;
  logic [W-1:0]   opb;
  logic [W-1:0]   result_hi;
  logic [W-1:0]   result_lo;
  logic           busy;
  logic           done;
  logic           div_zero;
  logic           overflow;

  int checks = 0;
  int errors = 0;

  ones_comp_seq_muldiv #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .opa       (opa),
    .opb       (opb),
    .result_hi (result_hi),
    .result_lo (result_lo),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint dec15(input logic [14:0] x);
    logic [13:0] m;
    m = x[14] ? ~x[13:0] : x[13:0];
    return x[14] ? -longint'(m) : longint'(m);
  endfunction

  function automatic longint dec30(input logic [29:0] x);
    logic [28:0] m;
    m = x[29] ? ~x[28:0] : x[28:0];
    return x[29] ? -longint'(m) : longint'(m);
  endfunction

  function automatic logic [14:0] enc15(input longint v);
    logic [14:0] r;
    if (v < 0) r = ~15'(-v);
    else       r = 15'(v);
    return r;
  endfunction

  function automatic logic [29:0] enc30(input longint v);
    logic [29:0] r;
    if (v < 0) r = ~30'(-v);
    else       r = 30'(v);
    return r;
  endfunction

  // Called #1 after a clock edge; start is sampled at the next edge (edge t).
  // lat counts edges after t until done is seen; poke re-asserts start at t+3.
  task automatic run_op(input string tag, input logic o, input logic [29:0] a,
                        input logic [14:0] b, input logic [14:0] e_hi, input logic [14:0] e_lo,
                        input logic e_dz, input logic e_ov, input int e_lat, input bit poke);
    int lat;
    start = 1'b1; op = o; opa = a; opb = b;
    @(posedge clk); #1;
    start = 1'b0; opa = ~a; opb = ~b;
    chk({tag, " busy"}, 32'(busy), 32'(e_lat != 0));
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (poke && lat == 2) begin start = 1'b1; op = ~o; opa = 30'h155; opb = 15'h0; end
      if (poke && lat == 3) start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(e_lat));
    chk({tag, " hi"}, 32'(result_hi), 32'(e_hi));
    chk({tag, " lo"}, 32'(result_lo), 32'(e_lo));
    chk({tag, " div_zero"}, 32'(div_zero), 32'(e_dz));
    chk({tag, " overflow"}, 32'(overflow), 32'(e_ov));
    chk({tag, " busy at done"}, 32'(busy), 32'(0));
    @(posedge clk); #1;
    chk({tag, " done pulse"}, 32'(done), 32'(0));
    chk({tag, " hi held"}, 32'(result_hi), 32'(e_hi));
  endtask

  task automatic run_mul_model(input string tag, input logic [14:0] a, input logic [14:0] b);
    logic [29:0] w;
    w = enc30(dec15(a) * dec15(b));
    run_op(tag, 1'b0, {15'($urandom), a}, b, w[29:15], w[14:0], 1'b0, 1'b0, W - 1, 1'b0);
  endtask

`ifdef OCMD_DIV_EN
  task automatic run_div_model(input string tag, input logic [29:0] a, input logic [14:0] b);
    longint vn, vd, an, ad;
    vn = dec30(a);
    vd = dec15(b);
    an = (vn < 0) ? -vn : vn;
    ad = (vd < 0) ? -vd : vd;
    if (ad == 0)
      run_op(tag, 1'b1, a, b, 15'h0, 15'h0, 1'b1, 1'b0, 0, 1'b0);
    else if ((an >> 14) >= ad)
      run_op(tag, 1'b1, a, b, 15'h0, 15'h0, 1'b0, 1'b1, 0, 1'b0);
    else
      run_op(tag, 1'b1, a, b, enc15(vn / vd), enc15(vn % vd), 1'b0, 1'b0, W - 1, 1'b0);
  endtask
`endif

  initial begin
    bit saw_done;
    rst = 1'b1; start = 1'b0; op = 1'b0; opa = '0; opb = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset hi", 32'(result_hi), 32'(0));
    chk("reset lo", 32'(result_lo), 32'(0));
    chk("reset busy", 32'(busy), 32'(0));
    chk("reset done", 32'(done), 32'(0));
    chk("reset div_zero", 32'(div_zero), 32'(0));
    chk("reset overflow", 32'(overflow), 32'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("t1 mul 3*-5", 1'b0, 30'h0003, 15'h7FFA, 15'h7FFF, 15'h7FF0, 1'b0, 1'b0, 14, 1'b0);
`ifdef OCMD_DIV_EN
    run_op("t2 div 100/-7", 1'b1, 30'd100, 15'h7FF8, 15'h7FF1, 15'h0002, 1'b0, 1'b0, 14, 1'b0);
    run_op("t3 div by -0", 1'b1, 30'h1234567, 15'h7FFF, 15'h0, 15'h0, 1'b1, 1'b0, 0, 1'b0);
    run_op("t4 div ovf", 1'b1, 30'h0010_0000, 15'h0003, 15'h0, 15'h0, 1'b0, 1'b1, 0, 1'b0);
`else
    run_op("t2 div disabled", 1'b1, 30'd100, 15'h7FF8, 15'h0, 15'h0, 1'b0, 1'b1, 0, 1'b0);
    run_op("t3 div disabled", 1'b1, 30'h1234567, 15'h7FFF, 15'h0, 15'h0, 1'b0, 1'b1, 0, 1'b0);
    run_op("t4 div disabled", 1'b1, 30'h0010_0000, 15'h0003, 15'h0, 15'h0, 1'b0, 1'b1, 0, 1'b0);
`endif
    run_op("t5 mul -0*5", 1'b0, 30'h7FFF, 15'h0005, 15'h0, 15'h0, 1'b0, 1'b0, 14, 1'b0);
    run_op("mul max poke", 1'b0, 30'h3FFF, 15'h3FFF, 15'h1FFF, 15'h0001, 1'b0, 1'b0, 14, 1'b1);

    // Abort an in-flight multiply with reset: no done, everything cleared.
    start = 1'b1; op = 1'b0; opa = 30'h0003; opb = 15'h7FFA;
    @(posedge clk); #1;
    start = 1'b0;
    saw_done = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      saw_done |= done;
      if (k == 2) start = 1'b1;
      if (k == 3) start = 1'b0;
      if (k == 4) rst = 1'b1;
      if (k == 5) rst = 1'b0;
    end
    chk("t6 no done", 32'(saw_done), 32'(0));
    chk("t6 busy", 32'(busy), 32'(0));
    chk("t6 hi", 32'(result_hi), 32'(0));
    chk("t6 lo", 32'(result_lo), 32'(0));
    chk("t6 flags", 32'({div_zero, overflow}), 32'(0));
    @(posedge clk); #1;
    chk("t6 idle done", 32'(done), 32'(0));
    run_op("t6 restart", 1'b0, 30'h0003, 15'h7FFA, 15'h7FFF, 15'h7FF0, 1'b0, 1'b0, 14, 1'b0);

    for (int i = 0; i < 30; i++) begin
      run_mul_model("rand mul", 15'($urandom), 15'($urandom));
    end
`ifdef OCMD_DIV_EN
    for (int i = 0; i < 30; i++) begin
      longint dm, nm;
      dm = longint'($urandom_range(1, 16383));
      nm = longint'($urandom) % (dm << 14);
      if (i % 7 == 3) nm = nm + (dm << 14);
      run_div_model("rand div", enc30(($urandom_range(0, 1) == 1) ? -nm : nm),
                    enc15(($urandom_range(0, 1) == 1) ? -dm : dm));
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
